// File: rtl/elevator_sched.sv
// ============================================================================
// Module   : elevator_sched
// Brief    : LOOK-policy request scheduler and motion/door sequencer for an
//            elevator car, with door-time occupancy tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_sched #(
    parameter int NUM_FLOORS = 8,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 4,
    parameter int MAX_PEOPLE = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic [NUM_FLOORS-1:0]         req,
    input  logic                          close,
    input  logic                          add,
    input  logic                          rem,
    output logic [$clog2(NUM_FLOORS)-1:0] floor,
    output logic                          dir,
    output logic                          moving,
    output logic                          door_open,
    output logic [NUM_FLOORS-1:0]         pending,
    output logic [$clog2(MAX_PEOPLE+1)-1:0] people,
    output logic                          full
);

    localparam int c_FW        = $clog2(NUM_FLOORS);
    localparam int c_PW        = $clog2(MAX_PEOPLE + 1);
    localparam int c_TIMER_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int c_TW        = $clog2(c_TIMER_MAX + 1);

    localparam logic [1:0] c_S_EVAL = 2'd0;
    localparam logic [1:0] c_S_MOVE = 2'd1;
    localparam logic [1:0] c_S_DOOR = 2'd2;

    logic [1:0]            r_state,   w_state_nxt;
    logic [c_FW-1:0]       r_floor,   w_floor_nxt;
    logic                  r_dir,     w_dir_nxt;
    logic [c_TW-1:0]       r_timer,   w_timer_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
    logic [c_PW-1:0]       r_people,  w_people_nxt;
    logic [NUM_FLOORS-1:0] w_clr;
    logic                  w_above, w_below, w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_EVAL;
            r_floor   <= '0;
            r_dir     <= 1'b1;
            r_timer   <= '0;
            r_pending <= '0;
            r_people  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_dir     <= w_dir_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
            r_people  <= w_people_nxt;
        end
    end

    assign w_full = (r_people == c_PW'(MAX_PEOPLE));

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir;
        w_timer_nxt  = r_timer;
        w_people_nxt = r_people;
        w_above      = 1'b0;
        w_below      = 1'b0;

        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (i > int'(r_floor))) w_above = 1'b1;
            if (r_pending[i] && (i < int'(r_floor))) w_below = 1'b1;
        end

        // A request for the floor whose door is open is served on the spot
        w_clr         = (r_state == c_S_DOOR) ? (NUM_FLOORS'(1) << r_floor) : '0;
        w_pending_nxt = (r_pending | req) & ~w_clr;

        case (r_state)
            c_S_EVAL: begin
                if (r_pending[r_floor]) begin
                    w_state_nxt = c_S_DOOR;
                    w_timer_nxt = c_TW'(DOOR_TICKS);
                end else if ((r_dir && w_above) || (!r_dir && w_below)) begin
                    w_state_nxt = c_S_MOVE;
                    w_timer_nxt = c_TW'(MOVE_TICKS);
                end else if (w_above || w_below) begin
                    w_dir_nxt   = w_above;
                    w_state_nxt = c_S_MOVE;
                    w_timer_nxt = c_TW'(MOVE_TICKS);
                end
            end
            c_S_MOVE: begin
                if (tick) begin
                    w_timer_nxt = r_timer - c_TW'(1);
                    if (r_timer == c_TW'(1)) begin
                        w_floor_nxt = r_dir ? (r_floor + c_FW'(1)) : (r_floor - c_FW'(1));
                        w_state_nxt = c_S_EVAL;
                    end
                end
            end
            c_S_DOOR: begin
                if (add && !rem && !w_full)
                    w_people_nxt = r_people + c_PW'(1);
                else if (rem && !add && (r_people != '0))
                    w_people_nxt = r_people - c_PW'(1);
                // Close takes precedence so a same-cycle tick is not consumed
                if (close) begin
                    w_state_nxt = c_S_EVAL;
                end else if (tick) begin
                    w_timer_nxt = r_timer - c_TW'(1);
                    if (r_timer == c_TW'(1)) w_state_nxt = c_S_EVAL;
                end
            end
            default: w_state_nxt = c_S_EVAL;
        endcase
    end

    assign floor     = r_floor;
    assign dir       = r_dir;
    assign moving    = (r_state == c_S_MOVE);
    assign door_open = (r_state == c_S_DOOR);
    assign pending   = r_pending;
    assign people    = r_people;
    assign full      = w_full;

endmodule

`default_nettype wire

// File: tb/tb_elevator_sched.sv
// ============================================================================
// Module   : tb_elevator_sched
// Brief    : Directed and random checks of elevator_sched against a
//            behavioural car model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_sched;

    logic       clk, rst_n, tick, close, add, rem;
    logic [7:0] req;
    logic [2:0] floor;
    logic       dir, moving, door_open, full;
    logic [7:0] pending;
    logic [2:0] people;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum int {IDLE, TRAVEL, OPEN} car_mode_t;
    car_mode_t  m_mode;
    int         m_floor, m_dir, m_timer, m_people;
    logic [7:0] m_pend;

    elevator_sched #(
        .NUM_FLOORS(8), .MOVE_TICKS(2), .DOOR_TICKS(4), .MAX_PEOPLE(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .close(close),
        .add(add), .rem(rem), .floor(floor), .dir(dir), .moving(moving),
        .door_open(door_open), .pending(pending), .people(people), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = IDLE; m_floor = 0; m_dir = 1; m_timer = 0; m_pend = '0; m_people = 0;
    endtask

    // One clock of the car, derived from the scheduling rules directly
    task automatic model_clock();
        int pv, above, below;
        logic [7:0] nxt_pend;
        pv       = int'(m_pend);
        nxt_pend = (m_pend | req) & ~((m_mode == OPEN) ? 8'(1 << m_floor) : 8'h00);
        case (m_mode)
            IDLE: begin
                above = ((pv >> (m_floor + 1)) != 0) ? 1 : 0;
                below = ((pv % (1 << m_floor)) != 0) ? 1 : 0;
                if (((pv >> m_floor) & 1) == 1) begin
                    m_mode = OPEN; m_timer = 4;
                end else if (above + below > 0) begin
                    if (m_dir == 1 && above == 0) m_dir = 0;
                    else if (m_dir == 0 && below == 0) m_dir = 1;
                    m_mode = TRAVEL; m_timer = 2;
                end
            end
            TRAVEL: if (tick) begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor += (m_dir == 1) ? 1 : -1;
                    m_mode = IDLE;
                end
            end
            OPEN: begin
                if (add && !rem && m_people < 7) m_people++;
                if (rem && !add && m_people > 0) m_people--;
                if (close) m_mode = IDLE;
                else if (tick) begin
                    m_timer--;
                    if (m_timer == 0) m_mode = IDLE;
                end
            end
            default: m_mode = IDLE;
        endcase
        m_pend = nxt_pend;
    endtask

    task automatic check_all();
        chk("floor",     32'(floor),     32'(m_floor));
        chk("dir",       32'(dir),       32'(m_dir));
        chk("moving",    32'(moving),    32'(m_mode == TRAVEL));
        chk("door_open", 32'(door_open), 32'(m_mode == OPEN));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("people",    32'(people),    32'(m_people));
        chk("full",      32'(full),      32'(m_people == 7));
    endtask

    task automatic step(input logic [7:0] r, input logic t, input logic c,
                        input logic a, input logic rm);
        req = r; tick = t; close = c; add = a; rem = rm;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
        req = '0; tick = 1'b0; close = 1'b0; add = 1'b0; rem = 1'b0;
    endtask

    task automatic run_until_door(input int bound);
        int k = 0;
        while (!door_open && k < bound) begin
            step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("reach_door", 32'(door_open), 32'd1);
    endtask

    task automatic count_door_ticks(output int cnt);
        cnt = 0;
        while (door_open && cnt < 20) begin
            step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; tick = 1'b0; req = '0; close = 1'b0; add = 1'b0; rem = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_floor", 32'(floor), 32'd0);
        chk("rst_dir",   32'(dir),   32'd1);
        #3 rst_n = 1'b1;

        // Single far request: climb to 5, open, close after four ticks
        step(8'b0010_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_door(40);
        chk("t1_floor", 32'(floor), 32'd5);
        step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_pending", 32'(pending), 32'd0);
        count_door_ticks(cnt);
        chk("t1_door_ticks", 32'(cnt + 1), 32'd4);

        // Arrive at 3 heading up, then serve 6 before reversing to 1
        step(8'b0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_door(40);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_door(40);
        chk("t2_at3", 32'(floor), 32'd3);
        chk("t2_dir_up", 32'(dir), 32'd1);
        step(8'b0100_0010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_until_door(40);
        chk("t2_first", 32'(floor), 32'd6);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_until_door(60);
        chk("t2_second", 32'(floor), 32'd1);
        chk("t2_dir_down", 32'(dir), 32'd0);

        // Occupancy saturation while the door is held open
        for (int i = 0; i < 8; i++) step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_people", 32'(people), 32'd7);
        chk("t4_full", 32'(full), 32'd1);
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_add_rem", 32'(people), 32'd7);

        // Own-floor request with door open is absorbed; door timer untouched
        step(8'b0000_0010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_pending", 32'(pending), 32'd0);
        count_door_ticks(cnt);
        chk("t5_door_ticks", 32'(cnt), 32'd4);

        // Close coinciding with tick shuts the door on the next cycle
        step(8'b0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until_door(40);
        step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_door", 32'(door_open), 32'd0);

        // Asynchronous reset in the middle of a move
        step(8'b1000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        while (!(floor == 3'd4 && moving) && cnt < 60) begin
            step(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            cnt++;
        end
        chk("t6_mid_move", 32'(floor == 3'd4 && moving), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_floor", 32'(floor), 32'd0);
        chk("t6_moving", 32'(moving), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
        check_all();
        #1 rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
